// File: rtl/rvfi_imem_arbiter.sv
// Round-robin arbiter sharing one imem model between fetch (port 0) and data reads (port 1).
// Optional WAIT-state abort enabled by defining RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN.
module rvfi_imem_arbiter #(
  parameter int XLEN    = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*XLEN-1:0]   req_addr,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [XLEN-1:0]     mem_addr,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  localparam logic [XLEN-1:0] HALF_MASK = ~XLEN'(1);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [1:0]          rv_q, rv_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          req_ready_c;
  logic                mem_valid_c;
  logic                grant;
  logic                timeout;
  logic [XLEN-1:0]     sel_addr;

  // Tie goes to the port that did not win last time.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_q;
      default: grant = 1'b0;
    endcase
  end

  assign sel_addr = grant ? req_addr[XLEN +: XLEN]
                          : req_addr[0 +: XLEN];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    rv_d        = 2'b00;
    rdata_d     = rdata_q;
    req_ready_c = 2'b00;
    mem_valid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready_c = grant ? 2'b10 : 2'b01;
          owner_d     = grant;
          last_d      = grant;
          addr_d      = sel_addr & HALF_MASK;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_valid_c = 1'b1;
        if (mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          rv_d    = owner_q ? 2'b10 : 2'b01;
          state_d = S_IDLE;
        end else if (timeout) begin
          rdata_d = '0;
          rv_d    = owner_q ? 2'b10 : 2'b01;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
      rv_q    <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Count restarts while issuing, so it is zero on the first WAIT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT && !mem_rvalid) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign timeout = (state_q == S_WAIT) && !mem_rvalid &&
                   (cnt_q == CW'(TIMEOUT - 1));
  assign err_d   = timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Gated so every output reads zero while reset is held.
  assign req_ready  = reset ? 2'b00 : req_ready_c;
  assign mem_valid  = mem_valid_c;
  assign mem_addr   = addr_q;
  assign resp_valid = rv_q;
  assign resp_data  = rdata_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rvfi_imem_arbiter.sv
// Directed bench for rvfi_imem_arbiter; timeout scenario follows
// RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN.
module tb_rvfi_imem_arbiter;

  localparam int XLEN   = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_addr;
  logic [1:0]        resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int tests = 0;
  int fails = 0;

  rvfi_imem_arbiter #(
    .XLEN(XLEN), .DATA_W(DATA_W), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 2'b00;
    req_addr = '0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_valid, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctl got %b exp 0",
               {req_ready, resp_valid, resp_err, mem_valid, busy});
    end
    tests++;
    if (resp_data !== 32'h0 || mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got %h/%h exp 0/0", resp_data, mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    req_valid = 2'b01;
    req_addr[31:0] = 32'h1003;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL basic_ready got %b exp 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tests++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h1002 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_issue got %b %h %b exp 1 00001002 1",
               mem_valid, mem_addr, busy);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tests++;
    if (mem_valid !== 1'b0 || resp_valid !== 2'b00) begin
      fails++;
      $display("FAIL basic_wait got %b %b exp 0 00", mem_valid, resp_valid);
    end
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b01 || resp_data !== 32'hDEADBEEF ||
        resp_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_resp got %b %h %b %b exp 01 deadbeef 0 0",
               resp_valid, resp_data, resp_err, busy);
    end
    tick();
    tests++;
    if (resp_valid !== 2'b00 || resp_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_hold got %b %h exp 00 deadbeef",
               resp_valid, resp_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  exp_oh;
    logic [31:0] exp_a;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    req_addr[31:0] = 32'h100;
    req_addr[63:32] = 32'h200;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a  = (i % 2 == 0) ? 32'h100 : 32'h200;
      tests++;
      if (req_ready !== exp_oh) begin
        fails++;
        $display("FAIL rr_grant%0d got %b exp %b", i, req_ready, exp_oh);
      end
      tick();
      tests++;
      if (mem_valid !== 1'b1 || mem_addr !== exp_a) begin
        fails++;
        $display("FAIL rr_addr%0d got %b %h exp 1 %h",
                 i, mem_valid, mem_addr, exp_a);
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hA0 + i;
      tick();
      mem_rvalid = 1'b0;
      if (i == 3) req_valid = 2'b00;
      tests++;
      if (resp_valid !== exp_oh || resp_data !== 32'hA0 + i) begin
        fails++;
        $display("FAIL rr_resp%0d got %b %h exp %b %h",
                 i, resp_valid, resp_data, exp_oh, 32'hA0 + i);
      end
      #1;
    end
  endtask

  task automatic test_stall;
    req_addr[31:0] = 32'h345;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h344 ||
          req_ready !== 2'b00) begin
        fails++;
        $display("FAIL stall%0d got %b %h %b exp 1 00000344 00",
                 i, mem_valid, mem_addr, req_ready);
      end
      tick();
    end
    req_valid = 2'b00;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b01 || resp_data !== 32'h5A5A5A5A) begin
      fails++;
      $display("FAIL stall_resp got %b %h exp 01 5a5a5a5a",
               resp_valid, resp_data);
    end
  endtask

  task automatic test_spurious;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b00 || busy !== 1'b0 ||
        resp_data !== 32'h5A5A5A5A) begin
      fails++;
      $display("FAIL spur_idle got %b %b %h exp 00 0 5a5a5a5a",
               resp_valid, busy, resp_data);
    end
    req_addr[63:32] = 32'h80;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b00 || mem_valid !== 1'b1) begin
      fails++;
      $display("FAIL spur_issue got %b %b exp 00 1", resp_valid, mem_valid);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tests++;
    if (resp_valid !== 2'b00 || busy !== 1'b1) begin
      fails++;
      $display("FAIL spur_wait got %b %b exp 00 1", resp_valid, busy);
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b10 || resp_data !== 32'h12345678) begin
      fails++;
      $display("FAIL spur_resp got %b %h exp 10 12345678",
               resp_valid, resp_data);
    end
  endtask

  task automatic test_reset_mid;
    req_addr[31:0] = 32'h40;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_valid, busy} !== 7'b0 ||
        resp_data !== 32'h0 || mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_async got %b %h %h exp 0 0 0",
               {req_ready, resp_valid, resp_err, mem_valid, busy},
               resp_data, mem_addr);
    end
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0BAD0BAD;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_stray got %b %b exp 00 0", resp_valid, busy);
    end
    req_addr[63:32] = 32'h2001;
    req_valid = 2'b10;
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL rst_grant got %b exp 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tests++;
    if (mem_addr !== 32'h2000) begin
      fails++;
      $display("FAIL rst_addr got %h exp 00002000", mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b10 || resp_data !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL rst_resp got %b %h exp 10 cafef00d",
               resp_valid, resp_data);
    end
  endtask

  task automatic test_timeout;
    req_addr[31:0] = 32'h10;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      tests++;
      if (resp_valid !== 2'b00 || busy !== 1'b1) begin
        fails++;
        $display("FAIL to_wait%0d got %b %b exp 00 1", w, resp_valid, busy);
      end
      tick();
    end
`ifdef RISCV_FORMAL_IMEM_ARB_TIMEOUT_EN
    tests++;
    if (resp_valid !== 2'b01 || resp_err !== 1'b1 ||
        resp_data !== 32'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_abort got %b %b %h %b exp 01 1 0 0",
               resp_valid, resp_err, resp_data, busy);
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'h99;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b00 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL to_stray got %b %b exp 00 0", resp_valid, resp_err);
    end
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h77;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if (resp_valid !== 2'b01 || resp_err !== 1'b0 ||
        resp_data !== 32'h77) begin
      fails++;
      $display("FAIL to_race got %b %b %h exp 01 0 77",
               resp_valid, resp_err, resp_data);
    end
`else
    for (int i = 0; i < 20; i++) tick();
    tests++;
    if (busy !== 1'b1 || resp_valid !== 2'b00 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL to_hang got %b %b %b exp 1 00 0",
               busy, resp_valid, resp_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
